// File: rtl/sgd_weight_updater_pkg.sv
// Shared types, constants and helpers for the SGD weight updater.
package sgd_weight_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   // Stages from read-address issue to the registered write port.
   localparam int unsigned PIPE_DEPTH = 4;

   // Clamp a sign-extended value to the signed range of a w-bit word (w <= 64).
   function automatic logic signed [63:0] saturate(input logic signed [63:0] x,
                                                   input int unsigned       w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (x > hi) return hi;
      if (x < lo) return lo;
      return x;
   endfunction

endpackage

// File: rtl/sgd_weight_updater_if.sv
// Memory-side bus of the weight updater: activation, delta and weight RAM ports.
interface sgd_weight_updater_if #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 11
);
   logic [ADDRESS_WIDTH-1:0] o_act_addr;
   logic [DATA_WIDTH-1:0]    i_act_data;
   logic [ADDRESS_WIDTH-1:0] o_delta_addr;
   logic [DATA_WIDTH-1:0]    i_delta_data;
   logic [ADDRESS_WIDTH-1:0] o_w_raddr;
   logic [DATA_WIDTH-1:0]    i_w_rdata;
   logic                     o_w_wen;
   logic [ADDRESS_WIDTH-1:0] o_w_waddr;
   logic [DATA_WIDTH-1:0]    o_w_wdata;

   modport master (
      output o_act_addr, o_delta_addr, o_w_raddr, o_w_wen, o_w_waddr, o_w_wdata,
      input  i_act_data, i_delta_data, i_w_rdata
   );

   modport slave (
      input  o_act_addr, o_delta_addr, o_w_raddr, o_w_wen, o_w_waddr, o_w_wdata,
      output i_act_data, i_delta_data, i_w_rdata
   );
endinterface

// File: rtl/sgd_weight_updater_fxp_mul_shift.sv
// Signed fixed-point multiply: full-width product, arithmetic shift right by FRAC_BITS.
module fxp_mul_shift #(
   parameter int DATA_WIDTH = 32,
   parameter int FRAC_BITS  = 24
) (
   input  logic signed [DATA_WIDTH-1:0] a,
   input  logic signed [DATA_WIDTH-1:0] b,
   output logic signed [DATA_WIDTH-1:0] y
);
   logic signed [2*DATA_WIDTH-1:0] prod;

   assign prod = a * b;
   assign y    = DATA_WIDTH'(prod >>> FRAC_BITS);
endmodule

// File: rtl/sgd_weight_updater.sv
// Streams every weight of a layer through w_new = sat(w - ((delta*act)*lr)), one per cycle.
//
// state | meaning
// IDLE  | waiting for i_valid; learning rate latched on acceptance
// RUN   | issuing read addresses for elements 0..N-1
// DRAIN | pipeline emptying; leaves after the last weight write
// DONE  | one-cycle o_valid pulse, then back to IDLE
module sgd_weight_updater
   import sgd_weight_pkg::*;
#(
   parameter int DATA_WIDTH            = 32,
   parameter int FRAC_BITS             = 24,
   parameter int ADDRESS_WIDTH         = 11,
   parameter int NUMBER_OF_INPUT_NODE  = 32,
   parameter int NUMBER_OF_OUTPUT_NODE = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_valid,
   input  logic [DATA_WIDTH-1:0] i_lr,
   output logic                  o_busy,
   output logic                  o_valid,
   sgd_weight_updater_if.master  mem
);
   localparam int N_COLS = NUMBER_OF_INPUT_NODE + 1;
   localparam int N_ELEM = NUMBER_OF_OUTPUT_NODE * N_COLS;

   typedef logic [ADDRESS_WIDTH-1:0]     addr_t;
   typedef logic signed [DATA_WIDTH-1:0] word_t;

   localparam addr_t LAST_K  = addr_t'(N_ELEM - 1);
   localparam addr_t LAST_I  = addr_t'(NUMBER_OF_INPUT_NODE);
   localparam word_t ACT_ONE = word_t'(1) <<< FRAC_BITS;

   if (longint'(N_ELEM) > (longint'(1) <<< ADDRESS_WIDTH)) begin : g_bad_addr
      $error("sgd_weight_updater: element count does not fit ADDRESS_WIDTH");
   end
   if (FRAC_BITS >= DATA_WIDTH) begin : g_bad_frac
      $error("sgd_weight_updater: FRAC_BITS must be below DATA_WIDTH");
   end
   if (DATA_WIDTH > 63) begin : g_bad_width
      $error("sgd_weight_updater: DATA_WIDTH above 63 is not supported");
   end

   state_e                state_q, state_d;
   addr_t                 k_q, k_d, i_q, i_d, j_q, j_d;
   word_t                 lr_q, lr_d;
   logic                  busy_q, busy_d, valid_q, valid_d;
   logic [PIPE_DEPTH-1:0] vld_q, vld_d;
   logic                  vld0_d;
   addr_t                 kdly_q [1:PIPE_DEPTH-1];
   addr_t                 kdly_d [1:PIPE_DEPTH-1];
   logic                  bias_q, bias_d;
   word_t                 p1_q, p1_d, w2_q, w2_d, step_q, step_d, w3_q, w3_d;
   word_t                 act_sel;
   logic signed [DATA_WIDTH:0] diff;
   logic                  wen_q, wen_d;
   addr_t                 waddr_q, waddr_d;
   word_t                 wdata_q, wdata_d;

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      i_d     = i_q;
      j_d     = j_q;
      lr_d    = lr_q;
      vld0_d  = 1'b0;
      valid_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_valid) begin
               state_d = RUN;
               k_d     = '0;
               i_d     = '0;
               j_d     = '0;
               vld0_d  = 1'b1;
               lr_d    = word_t'(i_lr);
            end
         end
         RUN: begin
            if (k_q == LAST_K) begin
               state_d = DRAIN;
            end else begin
               k_d    = k_q + addr_t'(1);
               vld0_d = 1'b1;
               if (i_q == LAST_I) begin
                  i_d = '0;
                  j_d = j_q + addr_t'(1);
               end else begin
                  i_d = i_q + addr_t'(1);
               end
            end
         end
         DRAIN: begin
            if (wen_q && (waddr_q == LAST_K)) begin
               state_d = DONE;
               valid_d = 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   // Element index, bias flag and valid travel alongside the data pipeline.
   always_comb begin
      vld_d     = {vld_q[PIPE_DEPTH-2:0], vld0_d};
      kdly_d[1] = k_q;
      for (int s = 2; s < PIPE_DEPTH; s++) begin
         kdly_d[s] = kdly_q[s-1];
      end
      bias_d = (i_q == LAST_I);
   end

   // Bias column multiplies by exactly 1.0; the activation RAM word is ignored.
   assign act_sel = bias_q ? ACT_ONE : word_t'(mem.i_act_data);

   fxp_mul_shift #(.DATA_WIDTH(DATA_WIDTH), .FRAC_BITS(FRAC_BITS)) u_mul_da (
      .a (word_t'(mem.i_delta_data)),
      .b (act_sel),
      .y (p1_d)
   );

   fxp_mul_shift #(.DATA_WIDTH(DATA_WIDTH), .FRAC_BITS(FRAC_BITS)) u_mul_lr (
      .a (p1_q),
      .b (lr_q),
      .y (step_d)
   );

   always_comb begin
      w2_d    = word_t'(mem.i_w_rdata);
      w3_d    = w2_q;
      diff    = {w3_q[DATA_WIDTH-1], w3_q} - {step_q[DATA_WIDTH-1], step_q};
      wen_d   = vld_q[PIPE_DEPTH-1];
      waddr_d = kdly_q[PIPE_DEPTH-1];
      wdata_d = wdata_q;
      if (vld_q[PIPE_DEPTH-1]) begin
         wdata_d = DATA_WIDTH'(saturate(64'(diff), DATA_WIDTH));
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q <= IDLE;
         k_q     <= '0;
         i_q     <= '0;
         j_q     <= '0;
         lr_q    <= '0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         vld_q   <= '0;
         for (int s = 1; s < PIPE_DEPTH; s++) kdly_q[s] <= '0;
         bias_q  <= 1'b0;
         p1_q    <= '0;
         w2_q    <= '0;
         step_q  <= '0;
         w3_q    <= '0;
         wen_q   <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         i_q     <= i_d;
         j_q     <= j_d;
         lr_q    <= lr_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
         vld_q   <= vld_d;
         for (int s = 1; s < PIPE_DEPTH; s++) kdly_q[s] <= kdly_d[s];
         bias_q  <= bias_d;
         p1_q    <= p1_d;
         w2_q    <= w2_d;
         step_q  <= step_d;
         w3_q    <= w3_d;
         wen_q   <= wen_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
      end
   end

   assign o_busy           = busy_q;
   assign o_valid          = valid_q;
   assign mem.o_w_raddr    = k_q;
   assign mem.o_act_addr   = i_q;
   assign mem.o_delta_addr = j_q;
   assign mem.o_w_wen      = wen_q;
   assign mem.o_w_waddr    = waddr_q;
   assign mem.o_w_wdata    = wdata_q;
endmodule

// File: tb/tb_sgd_weight_updater.sv
// Directed bench for sgd_weight_updater with N_IN=2, N_OUT=3 (9 weights per update).
module tb_sgd_weight_updater;
   localparam int DW = 32;
   localparam int FB = 24;
   localparam int AW = 11;
   localparam int NI = 2;
   localparam int NO = 3;
   localparam int NE = NO * (NI + 1);

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          i_valid = 1'b0;
   logic [DW-1:0] i_lr = '0;
   logic          o_busy;
   logic          o_valid;

   always #5 clk = ~clk;

   sgd_weight_updater_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) mem_if ();

   sgd_weight_updater #(
      .DATA_WIDTH(DW), .FRAC_BITS(FB), .ADDRESS_WIDTH(AW),
      .NUMBER_OF_INPUT_NODE(NI), .NUMBER_OF_OUTPUT_NODE(NO)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_valid (i_valid),
      .i_lr    (i_lr),
      .o_busy  (o_busy),
      .o_valid (o_valid),
      .mem     (mem_if)
   );

   // Synchronous-read RAM models, one cycle of latency.
   logic [31:0] act_mem [4];
   logic [31:0] delta_mem [4];
   logic [31:0] w_mem [16];
   logic [31:0] act_rd = '0, delta_rd = '0, w_rd = '0;

   always @(posedge clk) begin
      act_rd   <= act_mem[mem_if.o_act_addr[1:0]];
      delta_rd <= delta_mem[mem_if.o_delta_addr[1:0]];
      w_rd     <= w_mem[mem_if.o_w_raddr[3:0]];
   end
   assign mem_if.i_act_data   = act_rd;
   assign mem_if.i_delta_data = delta_rd;
   assign mem_if.i_w_rdata    = w_rd;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [31:0]       lr;
      logic [2:0][31:0]  d;
      logic [2:0][31:0]  a;
      logic [8:0][31:0]  w;
      logic [8:0][31:0]  e;
   } vec_t;

   vec_t vecs [3];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // One update from cycle A (i_valid high during A); checks every cycle A+1..A+NE+7.
   task automatic run_update(input int v, input bit spurious, input bit lr_change, input int rst_at);
      int  a;
      bit  aborted;
      bit  exp_wen;
      for (int x = 0; x < 3; x++) begin
         act_mem[x]   = vecs[v].a[x];
         delta_mem[x] = vecs[v].d[x];
      end
      for (int x = 0; x < NE; x++) w_mem[x] = vecs[v].w[x];
      @(negedge clk);
      a       = cyc;
      i_valid = 1'b1;
      i_lr    = vecs[v].lr;
      aborted = 1'b0;
      for (int off = 1; off <= NE + 7; off++) begin
         @(negedge clk);
         if (aborted) begin
            check("wen_after_reset",   32'(mem_if.o_w_wen), 32'd0);
            check("valid_after_reset", 32'(o_valid),        32'd0);
            check("busy_after_reset",  32'(o_busy),         32'd0);
         end else begin
            exp_wen = (off >= 5) && (off < 5 + NE);
            check("wen", 32'(mem_if.o_w_wen), 32'(exp_wen));
            if (exp_wen) begin
               check("waddr", 32'(mem_if.o_w_waddr), 32'(off - 5));
               check($sformatf("wdata_v%0d_k%0d", v, off - 5), mem_if.o_w_wdata, vecs[v].e[off - 5]);
            end
            check("valid", 32'(o_valid), 32'(off == 5 + NE));
            check("busy",  32'(o_busy),  32'(off <= 5 + NE));
         end
         if (off == 1) begin
            i_valid = 1'b0;
            if (lr_change) i_lr = 32'hFFFF_FFFF;
         end
         if (spurious && off == 3) i_valid = 1'b1;
         if (spurious && off == 4) i_valid = 1'b0;
         if (rst_at != 0 && off == rst_at) begin
            rst_n   = 1'b1;
            aborted = 1'b1;
         end
         if (rst_at != 0 && off == rst_at + 1) rst_n = 1'b0;
      end
   endtask

   initial begin
      // Vector 0: lr=0.5, main path and bias column (k=2 has w_old=0).
      vecs[0].lr = 32'h0080_0000;
      vecs[0].d[0] = 32'h0100_0000; vecs[0].d[1] = 32'h0200_0000; vecs[0].d[2] = 32'hFF00_0000;
      vecs[0].a[0] = 32'h0200_0000; vecs[0].a[1] = 32'h0040_0000; vecs[0].a[2] = 32'h1234_5678;
      vecs[0].w[0] = 32'h0300_0000; vecs[0].e[0] = 32'h0200_0000;
      vecs[0].w[1] = 32'h0300_0000; vecs[0].e[1] = 32'h02E0_0000;
      vecs[0].w[2] = 32'h0000_0000; vecs[0].e[2] = 32'hFF80_0000;
      vecs[0].w[3] = 32'h0300_0000; vecs[0].e[3] = 32'h0100_0000;
      vecs[0].w[4] = 32'h0300_0000; vecs[0].e[4] = 32'h02C0_0000;
      vecs[0].w[5] = 32'h0300_0000; vecs[0].e[5] = 32'h0200_0000;
      vecs[0].w[6] = 32'h0300_0000; vecs[0].e[6] = 32'h0400_0000;
      vecs[0].w[7] = 32'h0300_0000; vecs[0].e[7] = 32'h0320_0000;
      vecs[0].w[8] = 32'h0300_0000; vecs[0].e[8] = 32'h0380_0000;
      // Vector 1: lr=1.0, saturation at both rails, exact rails, floor truncation of negatives.
      vecs[1].lr = 32'h0100_0000;
      vecs[1].d[0] = 32'h0100_0000; vecs[1].d[1] = 32'hFF00_0000; vecs[1].d[2] = 32'hFFFF_FFFF;
      vecs[1].a[0] = 32'h0100_0000; vecs[1].a[1] = 32'h0080_0000; vecs[1].a[2] = 32'hDEAD_BEEF;
      vecs[1].w[0] = 32'h8000_0010; vecs[1].e[0] = 32'h8000_0000;
      vecs[1].w[1] = 32'h8080_0000; vecs[1].e[1] = 32'h8000_0000;
      vecs[1].w[2] = 32'h7FFF_FFFF; vecs[1].e[2] = 32'h7EFF_FFFF;
      vecs[1].w[3] = 32'h7FFF_FFF0; vecs[1].e[3] = 32'h7FFF_FFFF;
      vecs[1].w[4] = 32'h7F7F_FFFF; vecs[1].e[4] = 32'h7FFF_FFFF;
      vecs[1].w[5] = 32'h0000_0000; vecs[1].e[5] = 32'h0100_0000;
      vecs[1].w[6] = 32'h0000_0000; vecs[1].e[6] = 32'h0000_0001;
      vecs[1].w[7] = 32'h0000_0005; vecs[1].e[7] = 32'h0000_0006;
      vecs[1].w[8] = 32'h1234_5678; vecs[1].e[8] = 32'h1234_5679;
      // Vector 2: lr=2.0, negative activation, zero delta row, small delta.
      vecs[2].lr = 32'h0200_0000;
      vecs[2].d[0] = 32'h0080_0000; vecs[2].d[1] = 32'h0000_0000; vecs[2].d[2] = 32'h0001_0000;
      vecs[2].a[0] = 32'hFE00_0000; vecs[2].a[1] = 32'h0100_0000; vecs[2].a[2] = 32'h0000_0000;
      vecs[2].w[0] = 32'h0000_0000; vecs[2].e[0] = 32'h0200_0000;
      vecs[2].w[1] = 32'h0100_0000; vecs[2].e[1] = 32'h0000_0000;
      vecs[2].w[2] = 32'h0000_0000; vecs[2].e[2] = 32'hFF00_0000;
      vecs[2].w[3] = 32'h1111_1111; vecs[2].e[3] = 32'h1111_1111;
      vecs[2].w[4] = 32'h2222_2222; vecs[2].e[4] = 32'h2222_2222;
      vecs[2].w[5] = 32'hCAFE_BABE; vecs[2].e[5] = 32'hCAFE_BABE;
      vecs[2].w[6] = 32'h0000_0000; vecs[2].e[6] = 32'h0004_0000;
      vecs[2].w[7] = 32'h0010_0000; vecs[2].e[7] = 32'h000E_0000;
      vecs[2].w[8] = 32'h0000_0000; vecs[2].e[8] = 32'hFFFE_0000;
      for (int x = 0; x < 4; x++) begin
         act_mem[x]   = '0;
         delta_mem[x] = '0;
      end
      for (int x = 0; x < 16; x++) w_mem[x] = '0;

      repeat (3) @(negedge clk);
      check("rst_busy",   32'(o_busy),              32'd0);
      check("rst_valid",  32'(o_valid),             32'd0);
      check("rst_wen",    32'(mem_if.o_w_wen),      32'd0);
      check("rst_waddr",  32'(mem_if.o_w_waddr),    32'd0);
      check("rst_wdata",  mem_if.o_w_wdata,         32'd0);
      check("rst_raddr",  32'(mem_if.o_w_raddr),    32'd0);
      check("rst_aaddr",  32'(mem_if.o_act_addr),   32'd0);
      check("rst_daddr",  32'(mem_if.o_delta_addr), 32'd0);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);

      for (int v = 0; v < 3; v++) begin
         run_update(v, v == 0, v == 1, 0);
      end
      run_update(1, 1'b0, 1'b0, 7);
      run_update(0, 1'b0, 1'b0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/sgd_weight_updater.md
SGD_WEIGHT_UPDATER -- requirements
Module: sgd_weight_updater

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, signed fixed-point word width.
REQ-002 SHALL have parameter FRAC_BITS, default 24, fractional bits of every data word (1.0 = 1<<FRAC_BITS).
REQ-003 SHALL have parameter ADDRESS_WIDTH, default 11, width of all address ports.
REQ-004 SHALL have parameter NUMBER_OF_INPUT_NODE, default 32, activations per layer, excluding bias.
REQ-005 SHALL have parameter NUMBER_OF_OUTPUT_NODE, default 3, deltas per layer.
REQ-006 SHALL have ports clk, input, 1, the single clock; rst_n, input, 1, synchronous active-high reset (the codebase name is kept; asserted = 1).
REQ-007 SHALL have ports i_valid, input, 1, start request; i_lr, input, DATA_WIDTH, learning rate.
REQ-008 SHALL have ports o_busy, output, 1, update in progress; o_valid, output, 1, one-cycle done pulse.
REQ-009 SHALL have ports o_act_addr, output, ADDRESS_WIDTH; i_act_data, input, DATA_WIDTH; activation RAM, 1-cycle read latency.
REQ-010 SHALL have ports o_delta_addr, output, ADDRESS_WIDTH; i_delta_data, input, DATA_WIDTH; delta RAM, 1-cycle read latency.
REQ-011 SHALL have ports o_w_raddr, output, ADDRESS_WIDTH; i_w_rdata, input, DATA_WIDTH; weight read, 1-cycle latency.
REQ-012 SHALL have ports o_w_wen, output, 1; o_w_waddr, output, ADDRESS_WIDTH; o_w_wdata, output, DATA_WIDTH; weight write port.

Function
REQ-013 SHALL use FSM states IDLE, RUN, DRAIN, DONE; IDLE->RUN on i_valid in IDLE; RUN->DRAIN after last read issue; DRAIN->DONE after last write; DONE->IDLE unconditionally.
REQ-014 SHALL latch i_lr on acceptance; i_lr changes during an update SHALL have no effect.
REQ-015 SHALL ignore i_valid while not in IDLE (no restart, no queuing).
REQ-016 SHALL enumerate N = NUMBER_OF_OUTPUT_NODE*(NUMBER_OF_INPUT_NODE+1) elements k; j = k div (NUMBER_OF_INPUT_NODE+1), i = k mod (NUMBER_OF_INPUT_NODE+1); weight address = k, delta address = j, activation address = i.
REQ-017 SHALL treat i = NUMBER_OF_INPUT_NODE as bias: activation = 1.0, read data ignored.
REQ-018 SHALL compute step = ((delta*act)>>>FRAC_BITS * lr)>>>FRAC_BITS with full-width products and arithmetic-shift truncation; w_new = saturate(w_old - step) to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-019 SHALL, for acceptance edge at cycle A, present read addresses of element k in cycle A+1+k and assert o_w_wen with its result in cycle A+5+k (4-stage pipeline, one element per cycle).
REQ-020 SHALL pulse o_valid for exactly one cycle at A+5+N; o_busy SHALL be high from A+1 through A+5+N inclusive.
REQ-021 SHALL hold o_w_wen low outside scheduled writes; addresses are don't-care when unused.
REQ-022 SHALL fail elaboration when N > 2^ADDRESS_WIDTH or FRAC_BITS >= DATA_WIDTH.

Reset
REQ-023 SHALL, on rst_n = 1 at a clock edge, set state IDLE and o_busy, o_valid, o_w_wen, all addresses, o_w_wdata, and pipeline valids to 0.
REQ-024 SHALL, on reset mid-update, issue no further writes from the next cycle on and SHALL NOT pulse o_valid for the aborted update.

Structure
REQ-025 SHALL place the FSM state type, pipeline depth constant (4) and saturate function in package sgd_weight_pkg.
REQ-026 SHALL use one sub-module fxp_mul_shift (signed multiply, arithmetic right shift by FRAC_BITS), instantiated twice.

Verification (FRAC_BITS=24, N_IN=2, N_OUT=3, N=9)
REQ-027 SHALL check lr=0x00800000, delta=0x01000000, act=0x02000000, w_old=0x03000000 -> w_new=0x02000000.
REQ-028 SHALL check bias element, delta=0x01000000, lr=0x00800000, w_old=0 -> w_new=0xFF800000, activation data ignored.
REQ-029 SHALL check w_old=0x80000010, step=+0x01000000 -> w_new=0x80000000 (saturation).
REQ-030 SHALL check start at cycle A -> 9 writes at A+5..A+13, addresses 0..8 in order, o_valid only at A+14; i_valid at A+3 ignored.
REQ-031 SHALL check rst_n=1 at A+7 -> o_w_wen=0 from A+8, no o_valid; new i_valid afterwards gives full 9-write update.
